// File: rtl/puc_pkg.sv
// puc_pkg: shared fetch-sequencer state encoding and default widths
package puc_pkg;
  localparam int DEFAULT_INSTRUCTION_WIDTH = 40;
  localparam int DEFAULT_PC_WIDTH = 5;
  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;
endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: walks a program in external memory and streams words over a valid/ready port
module fetch_sequencer
  import puc_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = DEFAULT_INSTRUCTION_WIDTH,
  parameter int PC_WIDTH = DEFAULT_PC_WIDTH,
  parameter int PROGRAM_LENGTH = 12,
  parameter bit WRAP = 1'b0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         run,
  output logic [PC_WIDTH-1:0]          mem_pc,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_instruction,
  input  logic                         jump_valid,
  input  logic [PC_WIDTH-1:0]          jump_target,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
  output logic [PC_WIDTH-1:0]          out_pc,
  output logic                         halted,
  output logic                         error,
  output logic [15:0]                  issue_count
);
  state_t state;
  logic [PC_WIDTH-1:0] pc;
  logic accept, load, jump, bad_target, last;
  assign mem_pc = pc;
  assign halted = state == HALTED;
  assign accept = out_valid && out_ready;
  assign load = state == FETCH && run && (!out_valid || out_ready);
  assign jump = jump_valid && state != HALTED;
  assign bad_target = int'(jump_target) >= PROGRAM_LENGTH;
  assign last = pc == PC_WIDTH'(PROGRAM_LENGTH - 1);
  // A jump outranks both a load and the end-of-program halt; the acceptance is still counted.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      pc <= '0;
      out_valid <= 1'b0;
      out_instruction <= '0;
      out_pc <= '0;
      error <= 1'b0;
      issue_count <= '0;
    end else begin
      if (accept) issue_count <= issue_count + 16'd1;
      if (jump && bad_target) begin
        error <= 1'b1;
        state <= HALTED;
        out_valid <= 1'b0;
      end else if (jump) begin
        pc <= jump_target;
        out_valid <= 1'b0;
        state <= run ? FETCH : IDLE;
      end else if (load) begin
        out_instruction <= mem_instruction;
        out_pc <= pc;
        out_valid <= 1'b1;
        pc <= (last && WRAP) ? '0 : pc + PC_WIDTH'(1);
        state <= (last && !WRAP) ? HALTED : FETCH;
      end else begin
        if (accept) out_valid <= 1'b0;
        if (state != HALTED) state <= run ? FETCH : IDLE;
      end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench for a halting (dut0) and a wrapping (dut1) sequencer
module tb_fetch_sequencer;
  localparam int IW = 40;
  localparam int PW = 5;
  localparam int PL = 12;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic run = 1'b0;
  logic out_ready = 1'b0;
  logic [1:0] jump_valid = 2'b00;
  logic [PW-1:0] jump_target = '0;
  logic [1:0] out_valid, halted, error;
  logic [PW-1:0] mem_pc [2];
  logic [PW-1:0] out_pc [2];
  logic [IW-1:0] mem_instruction [2];
  logic [IW-1:0] out_instruction [2];
  logic [15:0] issue_count [2];
  int checks = 0;
  int errors = 0;
  int unsigned exp_q [2][$];
  int tail [2];
  int cnt [2];
  bit err [2];
  int delivered [2];

  always #5 clock = ~clock;
  // memory word n holds the value n
  assign mem_instruction[0] = IW'(mem_pc[0]);
  assign mem_instruction[1] = IW'(mem_pc[1]);

  fetch_sequencer #(.INSTRUCTION_WIDTH(IW), .PC_WIDTH(PW), .PROGRAM_LENGTH(PL), .WRAP(1'b0)) dut0 (
    .clock(clock), .reset_n(reset_n), .run(run), .mem_pc(mem_pc[0]),
    .mem_instruction(mem_instruction[0]), .jump_valid(jump_valid[0]), .jump_target(jump_target),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_instruction(out_instruction[0]),
    .out_pc(out_pc[0]), .halted(halted[0]), .error(error[0]), .issue_count(issue_count[0]));

  fetch_sequencer #(.INSTRUCTION_WIDTH(IW), .PC_WIDTH(PW), .PROGRAM_LENGTH(PL), .WRAP(1'b1)) dut1 (
    .clock(clock), .reset_n(reset_n), .run(run), .mem_pc(mem_pc[1]),
    .mem_instruction(mem_instruction[1]), .jump_valid(jump_valid[1]), .jump_target(jump_target),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_instruction(out_instruction[1]),
    .out_pc(out_pc[1]), .halted(halted[1]), .error(error[1]), .issue_count(issue_count[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected delivery stream: halting program runs start..PL-1, wrapping one cycles forever
  task automatic top_up(input int d);
    if (d == 0)
      while (tail[0] < PL) begin
        exp_q[0].push_back(tail[0]);
        tail[0]++;
      end
    else
      while (exp_q[1].size() < 2 * PL) begin
        exp_q[1].push_back(tail[1]);
        tail[1] = (tail[1] + 1) % PL;
      end
  endtask

  task automatic fill(input int d, input int start);
    exp_q[d].delete();
    tail[d] = start;
    top_up(d);
  endtask

  always @(negedge clock) begin
    int unsigned e;
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        fill(d, 0);
        cnt[d] = 0;
        err[d] = 1'b0;
      end else begin
        chk($sformatf("dut%0d issue_count", d), 64'(issue_count[d]), 64'(cnt[d]));
        chk($sformatf("dut%0d error", d), 64'(error[d]), 64'(err[d]));
        if (err[d]) begin
          chk($sformatf("dut%0d halted after bad jump", d), 64'(halted[d]), 64'd1);
          chk($sformatf("dut%0d out_valid after bad jump", d), 64'(out_valid[d]), 64'd0);
        end else if (d == 1 || exp_q[0].size() >= 2)
          chk($sformatf("dut%0d halted early", d), 64'(halted[d]), 64'd0);
        if (out_valid[d] && !err[d] && (d == 1 || int'(out_pc[d]) != PL - 1))
          chk($sformatf("dut%0d mem_pc ahead", d), 64'(mem_pc[d]), 64'((int'(out_pc[d]) + 1) % PL));
        if (out_valid[d])
          chk($sformatf("dut%0d out_instruction", d), 64'(out_instruction[d]), 64'(out_pc[d]));
        if (out_valid[d] && out_ready) begin
          if (exp_q[d].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d extra delivery: got out_pc %0d expected none", d, out_pc[d]);
          end else begin
            e = exp_q[d].pop_front();
            chk($sformatf("dut%0d delivered out_pc", d), 64'(out_pc[d]), 64'(e));
            if (d == 0 && e == PL - 1)
              chk("dut0 halted at last word", 64'(halted[0]), 64'd1);
          end
          cnt[d] = (cnt[d] + 1) & 16'hFFFF;
          delivered[d]++;
          top_up(d);
        end
        if (jump_valid[d] && !err[d]) begin
          if (int'(jump_target) >= PL) begin
            err[d] = 1'b1;
            exp_q[d].delete();
          end else
            fill(d, int'(jump_target));
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s dut%0d out_valid", tag, d), 64'(out_valid[d]), 64'd0);
      chk($sformatf("%s dut%0d out_pc", tag, d), 64'(out_pc[d]), 64'd0);
      chk($sformatf("%s dut%0d out_instruction", tag, d), 64'(out_instruction[d]), 64'd0);
      chk($sformatf("%s dut%0d halted", tag, d), 64'(halted[d]), 64'd0);
      chk($sformatf("%s dut%0d error", tag, d), 64'(error[d]), 64'd0);
      chk($sformatf("%s dut%0d issue_count", tag, d), 64'(issue_count[d]), 64'd0);
      chk($sformatf("%s dut%0d mem_pc", tag, d), 64'(mem_pc[d]), 64'd0);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run = 1'b0;
    out_ready = 1'b0;
    jump_valid = 2'b00;
    repeat (2) step();
    check_zero("reset");
    reset_n = 1'b1;
  endtask

  task automatic wait_pc(input int v);
    int n = 0;
    while (!(out_valid[0] && int'(out_pc[0]) == v) && n < 40) begin
      step();
      n++;
    end
    chk($sformatf("wait for out_pc %0d", v), 64'(n < 40), 64'd1);
  endtask

  initial begin
    // straight run: one word per cycle after the IDLE->FETCH cycle
    do_reset();
    run = 1'b1;
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 14; i++) begin
      step();
      for (int d = 0; d < 2; d++)
        if (d == 1 || i < PL) begin
          chk($sformatf("seq dut%0d out_valid", d), 64'(out_valid[d]), 64'd1);
          chk($sformatf("seq dut%0d out_pc", d), 64'(out_pc[d]), 64'(i % PL));
        end
    end
    chk("end dut0 out_valid", 64'(out_valid[0]), 64'd0);
    chk("end dut0 halted", 64'(halted[0]), 64'd1);
    chk("end dut0 issue_count", 64'(issue_count[0]), 64'd12);
    chk("wrap dut1 halted", 64'(halted[1]), 64'd0);
    // stall at 4, then jump 7 -> 2, then illegal jump
    do_reset();
    run = 1'b1;
    out_ready = 1'b1;
    wait_pc(4);
    out_ready = 1'b0;
    repeat (3) begin
      step();
      chk("stall out_pc", 64'(out_pc[0]), 64'd4);
      chk("stall out_valid", 64'(out_valid[0]), 64'd1);
      chk("stall mem_pc", 64'(mem_pc[0]), 64'd5);
    end
    out_ready = 1'b1;
    step();
    chk("resume out_pc", 64'(out_pc[0]), 64'd5);
    wait_pc(7);
    jump_valid = 2'b11;
    jump_target = 5'd2;
    step();
    jump_valid = 2'b00;
    chk("jump bubble", 64'(out_valid[0]), 64'd0);
    chk("jump issue_count", 64'(issue_count[0]), 64'd8);
    step();
    chk("jump first out_pc", 64'(out_pc[0]), 64'd2);
    step();
    chk("jump second out_pc", 64'(out_pc[0]), 64'd3);
    jump_valid = 2'b11;
    jump_target = 5'd15;
    step();
    jump_valid = 2'b11;
    jump_target = 5'd3;
    chk("bad jump error", 64'(error[0]), 64'd1);
    chk("bad jump halted", 64'(halted[0]), 64'd1);
    chk("bad jump out_valid", 64'(out_valid[0]), 64'd0);
    step();
    jump_valid = 2'b00;
    repeat (3) step();
    chk("ignored jump out_valid", 64'(out_valid[1]), 64'd0);
    chk("ignored jump halted", 64'(halted[1]), 64'd1);
    // asynchronous reset in mid-stream
    do_reset();
    run = 1'b1;
    out_ready = 1'b1;
    wait_pc(6);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("async reset");
    repeat (2) step();
    reset_n = 1'b1;
    repeat (2) step();
    chk("post reset out_pc", 64'(out_pc[0]), 64'd0);
    chk("post reset out_valid", 64'(out_valid[0]), 64'd1);
    // randomized traffic against the scoreboard
    delivered[0] = 0;
    delivered[1] = 0;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      repeat (80) begin
        step();
        run = $urandom_range(0, 9) != 0;
        out_ready = $urandom_range(0, 3) != 0;
        jump_target = ($urandom_range(0, 99) < 5) ? PW'($urandom_range(PL, 31)) : PW'($urandom_range(0, PL - 1));
        jump_valid[0] = ($urandom_range(0, 11) == 0) && exp_q[0].size() >= 2;
        jump_valid[1] = $urandom_range(0, 11) == 0;
      end
    end
    jump_valid = 2'b00;
    step();
    chk("random dut0 deliveries", 64'(delivered[0] > 20), 64'd1);
    chk("random dut1 deliveries", 64'(delivered[1] > 20), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
